core_fetch_ctrl: RTL and testbench

CORE_FETCH_CTRL -- requirements
Module: core_fetch_ctrl

---
 rtl/core_fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_core_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch_ctrl.sv
// Instruction fetch controller: single-outstanding L1I request FSM with stall buffering and redirect flush.
// Optional fetch timeout watchdog enabled by defining CORE_FETCH_TIMEOUT_EN.
module core_fetch_ctrl (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] pc_in,
    input  logic        stall_in,
    input  logic        redirect_val_in,
    input  logic [31:0] redirect_addr_in,
    output logic        l1i_req_val_out,
    output logic [31:0] l1i_addr_out,
    input  logic        l1i_req_rdy_in,
    input  logic        l1i_resp_val_in,
    input  logic [31:0] l1i_resp_data_in,
    output logic        if_pc_stop_out,
    output logic        if_mux_trn_s_out,
    output logic [31:0] if_addr_mux_trn_out,
    output logic        if_kill_out,
    output logic        if_enb_out,
    output logic        inst_val_out,
    output logic [31:0] inst_out,
    output logic        fetch_err_out
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StHold,
        StFlush
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] buf_q, buf_d;
    logic        timeout;
    logic        waiting;

    assign waiting = (state_q == StWait) || (state_q == StFlush);

`ifdef CORE_FETCH_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // Counter runs only while a request is outstanding and nothing has come back.
    always_comb begin
        timeout = waiting && !l1i_resp_val_in && (cnt_q == 8'hFF);
        cnt_d   = 8'h00;
        if (waiting && !l1i_resp_val_in && !timeout) begin
            cnt_d = cnt_q + 8'h01;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        buf_d            = buf_q;
        l1i_req_val_out  = 1'b0;
        if_pc_stop_out   = 1'b1;
        if_mux_trn_s_out = 1'b0;
        if_kill_out      = 1'b0;
        if_enb_out       = 1'b0;
        inst_val_out     = 1'b0;
        inst_out         = 32'h0;

        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                l1i_req_val_out = 1'b1;
                if (l1i_req_rdy_in) begin
                    state_d = redirect_val_in ? StFlush : StWait;
                end
            end
            StWait: begin
                if (l1i_resp_val_in) begin
                    if (redirect_val_in) begin
                        state_d = StFetch;
                    end else if (stall_in) begin
                        buf_d   = l1i_resp_data_in;
                        state_d = StHold;
                    end else begin
                        if_enb_out     = 1'b1;
                        inst_val_out   = 1'b1;
                        inst_out       = l1i_resp_data_in;
                        if_pc_stop_out = 1'b0;
                        state_d        = StFetch;
                    end
                end else if (timeout) begin
                    state_d = StFetch;
                end else if (redirect_val_in) begin
                    state_d = StFlush;
                end
            end
            StHold: begin
                if (redirect_val_in) begin
                    buf_d   = 32'h0;
                    state_d = StFetch;
                end else if (!stall_in) begin
                    if_enb_out     = 1'b1;
                    inst_val_out   = 1'b1;
                    inst_out       = buf_q;
                    if_pc_stop_out = 1'b0;
                    state_d        = StFetch;
                end
            end
            StFlush: begin
                // The response owed to the killed request is swallowed here.
                if (l1i_resp_val_in || timeout) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (redirect_val_in) begin
            if_mux_trn_s_out = 1'b1;
            if_pc_stop_out   = 1'b0;
            if_kill_out      = 1'b1;
            if_enb_out       = 1'b0;
            inst_val_out     = 1'b0;
            inst_out         = 32'h0;
        end
    end

    assign l1i_addr_out        = pc_in;
    assign if_addr_mux_trn_out = redirect_addr_in;
    assign fetch_err_out       = timeout;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            buf_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_core_fetch_ctrl.sv
// Randomized bench for core_fetch_ctrl against a transaction-level model of the fetch pipeline.
module tb_core_fetch_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] pc_in;
    logic        stall_in;
    logic        redirect_val_in;
    logic [31:0] redirect_addr_in;
    logic        l1i_req_val_out;
    logic [31:0] l1i_addr_out;
    logic        l1i_req_rdy_in;
    logic        l1i_resp_val_in;
    logic [31:0] l1i_resp_data_in;
    logic        if_pc_stop_out;
    logic        if_mux_trn_s_out;
    logic [31:0] if_addr_mux_trn_out;
    logic        if_kill_out;
    logic        if_enb_out;
    logic        inst_val_out;
    logic [31:0] inst_out;
    logic        fetch_err_out;

    int n_chk = 0;
    int n_bad = 0;

    core_fetch_ctrl u_dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .pc_in              (pc_in),
        .stall_in           (stall_in),
        .redirect_val_in    (redirect_val_in),
        .redirect_addr_in   (redirect_addr_in),
        .l1i_req_val_out    (l1i_req_val_out),
        .l1i_addr_out       (l1i_addr_out),
        .l1i_req_rdy_in     (l1i_req_rdy_in),
        .l1i_resp_val_in    (l1i_resp_val_in),
        .l1i_resp_data_in   (l1i_resp_data_in),
        .if_pc_stop_out     (if_pc_stop_out),
        .if_mux_trn_s_out   (if_mux_trn_s_out),
        .if_addr_mux_trn_out(if_addr_mux_trn_out),
        .if_kill_out        (if_kill_out),
        .if_enb_out         (if_enb_out),
        .inst_val_out       (inst_val_out),
        .inst_out           (inst_out),
        .fetch_err_out      (fetch_err_out)
    );

    always #5 clk = ~clk;

    // Model: pipeline bubble after reset, whether a request is in flight, whether its
    // reply is owed to a killed fetch, and any instruction parked while decode stalls.
    bit          m_bubble;
    bit          m_inflight;
    bit          m_doomed;
    logic [31:0] m_parked[$];
    int          m_wait;
    logic [31:0] m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_bubble   = 1'b1;
        m_inflight = 1'b0;
        m_doomed   = 1'b0;
        m_parked.delete();
        m_wait     = 0;
        m_pc       = 32'h0000_0100;
    endtask

    task automatic do_reset();
        @(negedge clk);
        stall_in         = 1'b0;
        redirect_val_in  = 1'b0;
        redirect_addr_in = 32'h0;
        l1i_req_rdy_in   = 1'b0;
        l1i_resp_val_in  = 1'b0;
        l1i_resp_data_in = 32'h0;
        #1 n_rst = 1'b0;
        #1;
        check("rst_stop", {31'h0, if_pc_stop_out}, 32'h1);
        check("rst_req", {31'h0, l1i_req_val_out}, 32'h0);
        check("rst_kill", {31'h0, if_kill_out}, 32'h0);
        check("rst_mux", {31'h0, if_mux_trn_s_out}, 32'h0);
        check("rst_enb", {31'h0, if_enb_out}, 32'h0);
        check("rst_ival", {31'h0, inst_val_out}, 32'h0);
        check("rst_inst", inst_out, 32'h0);
        check("rst_err", {31'h0, fetch_err_out}, 32'h0);
        model_reset();
        @(posedge clk);
        #1 n_rst = 1'b1;
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] ra,
                        input logic rdy, input logic rv, input logic [31:0] rdat);
        bit          fetching, deliver, tout;
        logic [31:0] data;
        @(negedge clk);
        stall_in         = st;
        redirect_val_in  = rd;
        redirect_addr_in = ra;
        l1i_req_rdy_in   = rdy;
        l1i_resp_val_in  = rv;
        l1i_resp_data_in = rdat;
        pc_in            = m_pc;
        #1;
        fetching = !m_bubble && !m_inflight && (m_parked.size() == 0);
`ifdef CORE_FETCH_TIMEOUT_EN
        tout = m_inflight && !rv && (m_wait == 255);
`else
        tout = 1'b0;
`endif
        deliver = 1'b0;
        data    = 32'h0;
        if (!rd) begin
            if (m_parked.size() != 0 && !st) begin
                deliver = 1'b1;
                data    = m_parked[0];
            end else if (m_inflight && !m_doomed && rv && !st) begin
                deliver = 1'b1;
                data    = rdat;
            end
        end
        check("req_val", {31'h0, l1i_req_val_out}, {31'h0, fetching});
        check("addr", l1i_addr_out, m_pc);
        check("pc_stop", {31'h0, if_pc_stop_out}, {31'h0, !(rd || deliver)});
        check("mux_s", {31'h0, if_mux_trn_s_out}, {31'h0, rd});
        check("mux_addr", if_addr_mux_trn_out, ra);
        check("kill", {31'h0, if_kill_out}, {31'h0, rd});
        check("enb", {31'h0, if_enb_out}, {31'h0, deliver});
        check("inst_val", {31'h0, inst_val_out}, {31'h0, deliver});
        check("inst", inst_out, data);
        check("err", {31'h0, fetch_err_out}, {31'h0, tout});
        @(posedge clk);
        if (rd) m_pc = ra;
        else if (deliver) m_pc = m_pc + 32'd4;
        if (m_bubble) begin
            m_bubble = 1'b0;
        end else if (m_parked.size() != 0) begin
            if (rd || !st) m_parked.delete();
        end else if (m_inflight) begin
            if (rv) begin
                if (!m_doomed && !rd && st) m_parked.push_back(rdat);
                m_inflight = 1'b0;
                m_doomed   = 1'b0;
            end else if (tout) begin
                m_inflight = 1'b0;
                m_doomed   = 1'b0;
            end else if (rd) begin
                m_doomed = 1'b1;
            end
            m_wait = m_inflight ? m_wait + 1 : 0;
        end else if (rdy) begin
            m_inflight = 1'b1;
            m_doomed   = rd;
            m_wait     = 0;
        end
    endtask

    initial begin
        n_rst            = 1'b1;
        pc_in            = 32'h0;
        stall_in         = 1'b0;
        redirect_val_in  = 1'b0;
        redirect_addr_in = 32'h0;
        l1i_req_rdy_in   = 1'b0;
        l1i_resp_val_in  = 1'b0;
        l1i_resp_data_in = 32'h0;
        model_reset();
        do_reset();

        // Basic fetch: IDLE, FETCH (accepted), WAIT, WAIT with response.
        step(0, 0, 32'h0, 1, 0, 32'h0);
        step(0, 0, 32'h0, 1, 0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 1, 32'h0000_0013);

        // Response under stall, held for three cycles, then released.
        step(0, 0, 32'h0, 1, 0, 32'h0);
        step(1, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0, 1, 32'h1111_1111);
        step(0, 0, 32'h0, 0, 0, 32'h0);

        // Redirect in WAIT, then the stale response must be dropped.
        step(0, 0, 32'h0, 1, 0, 32'h0);
        step(0, 1, 32'h0000_0200, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 1, 32'hBAD0_BAD0);
        step(0, 0, 32'h0, 1, 0, 32'h0);

        // Redirect coincident with a response in WAIT.
        step(0, 0, 32'h0, 0, 0, 32'h0);
        step(0, 1, 32'h0000_0300, 0, 1, 32'h2222_2222);
        step(0, 0, 32'h0, 1, 0, 32'h0);

        // Long silence from L1I.
        for (int i = 0; i < 300; i++) step(i[0], 0, 32'h0, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 1, 32'h3333_3333);

        // Reset with a request outstanding, followed by a late response.
        step(0, 0, 32'h0, 1, 0, 32'h0);
        do_reset();
        step(0, 0, 32'h0, 0, 1, 32'h4444_4444);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 {$urandom_range(0, 255), 2'b00} << 4,
                 $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
